// File: rtl/mux_recirculacion_tx_pkg.sv
// Shared constants, state encoding and lane gating helper for the 4-lane
// recirculating transmit serializer.
package mux_recirculacion_tx_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  localparam logic [LANE_W-1:0] LAST_SLOT = LANE_W'(LANES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // An invalid lane still occupies its slot but never leaks stale data.
  function automatic logic [DATA_W-1:0] gate_lane(input logic v, input logic [DATA_W-1:0] d);
    return v ? d : '0;
  endfunction

endpackage

// File: rtl/mux_recirculacion_tx_if.sv
// Frame-load handshake plus serialized lane output bundle between source and serializer.
interface mux_recirculacion_tx_if;
  import mux_recirculacion_tx_pkg::*;

  logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
  logic              valid_0, valid_1, valid_2, valid_3;
  logic              in_load;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [LANE_W-1:0] lane_out;
  logic              frame_start;
  logic              idle_out;
  logic              overrun;

  modport master (
    output data_0, data_1, data_2, data_3,
    output valid_0, valid_1, valid_2, valid_3,
    output in_load,
    input  in_ready, data_out, valid_out, lane_out, frame_start, idle_out, overrun
  );

  modport slave (
    input  data_0, data_1, data_2, data_3,
    input  valid_0, valid_1, valid_2, valid_3,
    input  in_load,
    output in_ready, data_out, valid_out, lane_out, frame_start, idle_out, overrun
  );

endinterface

// File: rtl/mux_recirculacion_tx_lane_hold_4x.sv
// Four-lane data+valid holding bank: loads a whole frame at once, read one lane at a time.
module lane_hold_4x
  import mux_recirculacion_tx_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic [LANES-1:0][DATA_W-1:0] data_i,
  input  logic [LANES-1:0]             valid_i,
  input  logic [LANE_W-1:0]            sel_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         valid_o
);

  logic [LANES-1:0][DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q[sel_i];
  assign valid_o = valid_q[sel_i];

endmodule

// File: rtl/mux_recirculacion_tx.sv
// Serializes a 4-lane frame onto one byte lane, one lane per clock, with
// back-to-back reload in the last slot and idle/overrun status.
module mux_recirculacion_tx
  import mux_recirculacion_tx_pkg::*;
(
  input  logic                  clk_4f,
  input  logic                  reset,
  mux_recirculacion_tx_if.slave bus
);

  state_t            state_q, state_d;
  logic [LANE_W-1:0] slot_q, slot_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic [LANE_W-1:0] lane_out_q, lane_out_d;
  logic              frame_start_q, frame_start_d;
  logic              idle_out_q, idle_out_d;
  logic              overrun_q, overrun_d;

  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;

  // slot_q names the lane that the next edge puts on the outputs.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_SEND) && (slot_q == LAST_SLOT));
  assign accept   = bus.in_load && in_ready;

  lane_hold_4x u_hold (
    .clk_i   (clk_4f),
    .rst_i   (reset),
    .load_i  (accept),
    .data_i  ({bus.data_3, bus.data_2, bus.data_1, bus.data_0}),
    .valid_i ({bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0}),
    .sel_i   (slot_q),
    .data_o  (hold_data),
    .valid_o (hold_valid)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    data_out_d    = '0;
    valid_out_d   = 1'b0;
    lane_out_d    = '0;
    frame_start_d = 1'b0;
    idle_out_d    = 1'b1;
    overrun_d     = bus.in_load && !in_ready;

    if (state_q == ST_SEND) begin
      data_out_d    = gate_lane(hold_valid, hold_data);
      valid_out_d   = hold_valid;
      lane_out_d    = slot_q;
      frame_start_d = (slot_q == '0);
      idle_out_d    = 1'b0;
      // Wraps to 0; an accept in the last slot keeps streaming without a gap.
      slot_d        = slot_q + 2'd1;
      if ((slot_q == LAST_SLOT) && !accept) state_d = ST_IDLE;
    end else if (accept) begin
      state_d = ST_SEND;
      slot_d  = '0;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      lane_out_q    <= '0;
      frame_start_q <= 1'b0;
      idle_out_q    <= 1'b1;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      lane_out_q    <= lane_out_d;
      frame_start_q <= frame_start_d;
      idle_out_q    <= idle_out_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.lane_out    = lane_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.idle_out    = idle_out_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_mux_recirculacion_tx.sv
// Scoreboard bench: a lane-queue reference model predicts every cycle's outputs,
// a negedge monitor pops and compares.
module tb_mux_recirculacion_tx;

  logic clk;
  logic rst;

  mux_recirculacion_tx_if bus();

  mux_recirculacion_tx dut (
    .clk_4f (clk),
    .reset  (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] ln;
  } lane_t;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] ln;
    logic       fs;
    logic       idl;
    logic       ov;
    logic       rdy;
  } exp_t;

  lane_t pend[$];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Reference: a frame becomes four pending lanes; one lane leaves per clock,
  // and a new frame is taken only when at most one lane is still pending.
  always @(posedge clk) begin
    exp_t       e;
    lane_t      l;
    logic       rdy;
    logic [7:0] db[4];
    logic [3:0] vb;
    e.d = 8'h00; e.v = 1'b0; e.ln = 2'd0; e.fs = 1'b0; e.idl = 1'b1; e.ov = 1'b0; e.rdy = 1'b1;
    if (rst) begin
      pend.delete();
    end else begin
      db[0] = bus.data_0; db[1] = bus.data_1; db[2] = bus.data_2; db[3] = bus.data_3;
      vb = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
      rdy = (pend.size() <= 1);
      e.ov = bus.in_load && !rdy;
      if (pend.size() > 0) begin
        l = pend.pop_front();
        e.d = l.d; e.v = l.v; e.ln = l.ln; e.fs = (l.ln == 2'd0); e.idl = 1'b0;
      end
      if (bus.in_load && rdy) begin
        for (int k = 0; k < 4; k++) begin
          l.v  = vb[k];
          l.d  = vb[k] ? db[k] : 8'h00;
          l.ln = 2'(k);
          pend.push_back(l);
        end
      end
      e.rdy = (pend.size() <= 1);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty t=%0t no expectation queued", $time);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus.data_out !== e.d || bus.valid_out !== e.v || bus.lane_out !== e.ln ||
          bus.frame_start !== e.fs || bus.idle_out !== e.idl || bus.overrun !== e.ov ||
          bus.in_ready !== e.rdy) begin
        n_err++;
        $display("FAIL slot t=%0t got d=%h v=%b ln=%0d fs=%b idle=%b ovr=%b rdy=%b exp d=%h v=%b ln=%0d fs=%b idle=%b ovr=%b rdy=%b",
                 $time, bus.data_out, bus.valid_out, bus.lane_out, bus.frame_start, bus.idle_out,
                 bus.overrun, bus.in_ready, e.d, e.v, e.ln, e.fs, e.idl, e.ov, e.rdy);
      end
    end
  end

  task automatic step(input logic ld, input logic [31:0] d, input logic [3:0] v);
    bus.in_load = ld;
    bus.data_0  = d[31:24];
    bus.data_1  = d[23:16];
    bus.data_2  = d[15:8];
    bus.data_3  = d[7:0];
    bus.valid_0 = v[0];
    bus.valid_1 = v[1];
    bus.valid_2 = v[2];
    bus.valid_3 = v[3];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 4'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    bus.in_load = 1'b0;
    bus.data_0 = 8'h00; bus.data_1 = 8'h00; bus.data_2 = 8'h00; bus.data_3 = 8'h00;
    bus.valid_0 = 1'b0; bus.valid_1 = 1'b0; bus.valid_2 = 1'b0; bus.valid_3 = 1'b0;
    // Loads offered during reset must be ignored.
    step(1'b1, 32'h12345678, 4'hF);
    step(1'b1, 32'h9abcdef0, 4'hF);
    step(1'b0, 32'h0, 4'h0);
    rst = 1'b0;
    idle(5);

    step(1'b1, 32'hffeeddcc, 4'b1111);
    idle(6);

    step(1'b1, 32'hbbaa9988, 4'b1111);
    idle(3);
    step(1'b1, {8'($urandom), 8'($urandom), 8'h77, 8'($urandom)}, 4'b0100);
    idle(6);

    for (int i = 0; i < 12; i++) step(1'b1, $urandom, 4'b1111);
    idle(6);

    step(1'b1, 32'h55555555, 4'b0000);
    idle(6);

    // Asynchronous reset while lane 2 is on the outputs.
    step(1'b1, 32'h11223344, 4'b1111);
    idle(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0 || bus.lane_out !== 2'd0 ||
        bus.idle_out !== 1'b1 || bus.frame_start !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset got d=%h v=%b ln=%0d idle=%b fs=%b rdy=%b exp d=00 v=0 ln=0 idle=1 fs=0 rdy=1",
               bus.data_out, bus.valid_out, bus.lane_out, bus.idle_out, bus.frame_start, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);

    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 2) != 0), $urandom, 4'($urandom));
    end
    idle(6);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
